// File: rtl/expr_defs.sv
// Shared definitions for the expression-protocol transmitter and recognizer.
// Character constants, FSM state encodings and the default term count.
package expr_defs;

  localparam int MAXN_DEF = 8;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_TERM = 8'h3D;
  localparam logic [7:0] CH_NUL  = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIG  = 2'd1,
    OP   = 2'd2,
    TERM = 2'd3
  } state_e;

  function automatic logic [3:0] clamp9(
    input logic [3:0] d
  );
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/expr_char_enc.sv
// Combinational character encoder: (state, digit, op bit) -> ASCII byte.
// Digits above 9 are clamped to '9'.
module expr_char_enc
  import expr_defs::*;
(
  input  logic [1:0] state_i,
  input  logic [3:0] nib_i,
  input  logic       op_i,
  output logic [7:0] ch_o
);

  state_e st;

  always_comb begin
    st   = state_e'(state_i);
    ch_o = CH_NUL;
    unique case (st)
      IDLE: ch_o = CH_NUL;
      DIG:  ch_o = CH_ZERO + {4'h0, clamp9(nib_i)};
      OP:   ch_o = op_i ? CH_MUL : CH_PLUS;
      TERM: ch_o = CH_TERM;
    endcase
  end

endmodule

// File: rtl/expr_tx.sv
// Expression string transmitter: sends digit (op digit)* under valid/rdy.
// Define EXPR_TX_TERM_EN to append a trailing '=' terminator.
module expr_tx
  import expr_defs::*;
#(
  parameter int MAXN = MAXN_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        nterm,
  input  logic [4*MAXN-1:0] dig,
  input  logic [MAXN-2:0]   opsel,
  input  logic              rdy,
  output logic [7:0]        out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] MAXN_L = 4'(MAXN);

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [3:0]        nterm_q, nterm_d;
  logic [4*MAXN-1:0] dig_q, dig_d;
  logic [MAXN-2:0]   opsel_q, opsel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [3:0] nib;
  logic       opb;
  logic       start_ok;
  logic       xfer;
  logic       last;

  // Current term's digit and following operator, selected by k.
  always_comb begin
    nib = 4'h0;
    opb = 1'b0;
    for (int i = 0; i < MAXN; i++) begin
      if (k_q == 4'(i)) nib = dig_q[4*i +: 4];
    end
    for (int i = 0; i < MAXN - 1; i++) begin
      if (k_q == 4'(i)) opb = opsel_q[i];
    end
  end

  assign start_ok = (nterm != 4'd0) && (nterm <= MAXN_L);
  assign valid    = (state_q != IDLE);
  assign busy     = valid;
  assign xfer     = valid && rdy;
  assign last     = (k_q == nterm_q - 4'd1);
  assign done     = done_q;
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    nterm_d = nterm_q;
    dig_d   = dig_q;
    opsel_d = opsel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            dig_d   = dig;
            opsel_d = opsel;
            nterm_d = nterm;
            k_d     = 4'd0;
            state_d = DIG;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DIG: begin
        if (xfer) begin
          if (last) begin
`ifdef EXPR_TX_TERM_EN
            state_d = TERM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = OP;
          end
        end
      end
      OP: begin
        if (xfer) begin
          k_d     = k_q + 4'd1;
          state_d = DIG;
        end
      end
      TERM: begin
`ifdef EXPR_TX_TERM_EN
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      nterm_q <= 4'd0;
      dig_q   <= '0;
      opsel_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      nterm_q <= nterm_d;
      dig_q   <= dig_d;
      opsel_q <= opsel_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  expr_char_enc u_enc (
    .state_i (state_q),
    .nib_i   (nib),
    .op_i    (opb),
    .ch_o    (out)
  );

endmodule
